beta_muldiv: RTL
================

# beta_muldiv

Iterative signed multiply/divide unit for the Beta execute stage. Sits beside the combinational ALU on the same operand buses and serves the opcodes the ALU does not implement (MUL, DIV). The execute stage muxes its result onto the same writeback path as the ALU output. It stalls the pipeline through a valid/ready handshake on both sides.

## Interface
- WIDTH, 32, operand/result width; iteration count equals WIDTH.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  unit idle and able to accept.
- op  in  1  0 = MUL, 1 = DIV.
- a  in  WIDTH  operand A (multiplicand / dividend), two's complement.
- b  in  WIDTH  operand B (multiplier / divisor), two's complement.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- y  out  WIDTH  result (product low word / quotient).
- div_zero  out  1  result came from DIV with b == 0; qualified by out_valid.

## Operation
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE: in_ready = 1. On in_valid at an edge:
  - latch op;
  - latch |a|, |b| and result sign (a[WIDTH-1] ^ b[WIDTH-1] for DIV; no sign handling for MUL, raw operands latched);
  - clear the iteration counter;
  - go to RUN.
- RUN: one iteration per cycle, WIDTH cycles; counter wraps from WIDTH-1 to FIX.
  - MUL: shift-add, keeping only the low WIDTH bits of the product. Signed and unsigned low words are identical.
  - DIV: restoring division on magnitudes, 2*WIDTH-bit remainder/quotient register, one quotient bit per cycle.
- FIX:
  - DIV: negate the quotient if sign = 1. Truncation toward zero.
  - b == 0: y = all ones, div_zero = 1.
  - MUL: pass the product through.
  - Register y and go to DONE.
- DONE: out_valid = 1. y and div_zero are held stable until out_ready; on out_ready go to IDLE.
- Overflow: DIV of most-negative by -1 yields most-negative (0x80000000), div_zero = 0. MUL overflow silently truncates.
- The remainder is not exposed.
- in_ready is low in RUN, FIX and DONE. in_valid there is ignored; the requester holds it.
- No same-cycle reuse: the out_ready handshake at the DONE exit edge returns to IDLE, and in_ready rises the following cycle.

## Timing
- Reset values after a rst edge: state IDLE, in_ready 1, out_valid 0, y 0, div_zero 0, counter 0.
- No accept occurs on an edge where rst is high.
- Latency, with acceptance at edge E0:
  - RUN occupies edges E1..E32;
  - FIX executes at edge E33;
  - out_valid is high from E33 until handshake;
  - total is WIDTH+1 cycles, identical for MUL, DIV and divide-by-zero.
- Minimum issue interval: WIDTH+3 cycles (accept, WIDTH iterations, FIX, DONE handshake, IDLE).
- Reset mid-operation (any state) aborts: next cycle is IDLE with reset values. A partially computed result is never presented.
- in_ready and out_valid are decoded from state only, with no combinational path from in_valid or out_ready.

## Structure
- beta_pkg holds:
  - muldiv_op_t enum (MD_MUL = 0, MD_DIV = 1);
  - muldiv_state_t enum (IDLE, RUN, FIX, DONE);
  - BETA_XLEN = 32 as the default for WIDTH.
- Single module, no sub-module: FSM, counter ($clog2(WIDTH)+1 bits) and a shared shift register datapath in one file.
- The execute-stage mux selecting beta_muldiv.y versus the ALU result lives in the execute stage, not here.

## Test plan
- MUL a=7, b=6 accepted at E0 -> out_valid rises at E33, y=42, div_zero=0; in_ready low E0..handshake.
- MUL a=0xFFFFFFFF, b=3 -> y=0xFFFFFFFD. MUL a=0x10000, b=0x10000 -> y=0.
- DIV a=-7, b=2 -> y=0xFFFFFFFD (-3). DIV a=7, b=-2 -> -3. DIV a=-7, b=-2 -> 3. DIV a=0x80000000, b=-1 -> 0x80000000.
- DIV a=123, b=0 -> y=0xFFFFFFFF, div_zero=1, same 33-cycle latency; the following MUL reports div_zero=0.
- Backpressure: out_ready low for 5 cycles after out_valid -> y and div_zero stable, a new in_valid is not accepted. out_ready high -> IDLE next cycle, and a back-to-back request is accepted the cycle after.
- rst asserted during RUN iteration 10 -> next cycle in_ready=1, out_valid=0, y=0. A fresh DIV 100/7 then returns 14.

Source files
------------

// File: rtl/beta_pkg.sv
// Shared types and constants for the Beta execute stage.
//   muldiv_op_t    : operation select for beta_muldiv (MUL / DIV)
//   muldiv_state_t : beta_muldiv control FSM states
//   BETA_XLEN      : architectural register width
package beta_pkg;

    localparam int BETA_XLEN = 32;

    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/beta_muldiv.sv
// Iterative signed multiply/divide unit for the Beta execute stage.
// One iteration per cycle over WIDTH cycles, then a fix-up cycle, with a
// valid/ready handshake on both the request and the result side.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid / in_ready request handshake (in_ready high only when idle)
//   op                  0 = MUL (low product word), 1 = DIV (quotient)
//   a, b                two's complement operands
//   out_valid/out_ready result handshake (y, div_zero held until taken)
//   y                   product low word or quotient
//   div_zero            result came from DIV with b == 0
module beta_muldiv
    import beta_pkg::*;
#(
    parameter int WIDTH = BETA_XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Magnitude of a two's complement value; the most negative value maps
    // to its own bit pattern, which is correct when read as unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic            neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // Control state (reset)
    muldiv_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             dz_q, dz_d;

    // Datapath state (no reset; always loaded on accept before use)
    muldiv_op_t         op_q, op_d;
    logic               sign_q, sign_d;
    logic               bzero_q, bzero_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;     // MUL: shifting multiplicand, DIV: |b|
    logic [2*WIDTH-1:0] acc_q, acc_d;       // MUL: {product, multiplier}, DIV: {rem, quo}

    logic [2*WIDTH:0]   sh;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   mul_sum;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        dz_d    = dz_q;
        op_d    = op_q;
        sign_d  = sign_q;
        bzero_d = bzero_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;

        // Restoring-division trial: shift {rem,quo} left, subtract divisor
        // from the (WIDTH+1)-bit partial remainder.
        sh      = {acc_q, 1'b0};
        diff    = sh[2*WIDTH:WIDTH] - {1'b0, opnd_q};
        // Shift-add: multiplier LSB sits at acc_q[0], multiplicand shifts left.
        mul_sum = acc_q[2*WIDTH-1:WIDTH] + (acc_q[0] ? opnd_q : '0);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = muldiv_op_t'(op);
                    cnt_d   = '0;
                    bzero_d = (b == '0);
                    state_d = RUN;
                    if (muldiv_op_t'(op) == MD_DIV) begin
                        opnd_d = mag(b);
                        acc_d  = {{WIDTH{1'b0}}, mag(a)};
                        sign_d = a[WIDTH-1] ^ b[WIDTH-1];
                    end else begin
                        opnd_d = a;
                        acc_d  = {{WIDTH{1'b0}}, b};
                        sign_d = 1'b0;
                    end
                end
            end
            RUN: begin
                if (op_q == MD_DIV) begin
                    if (!diff[WIDTH]) begin
                        acc_d = {diff[WIDTH-1:0], sh[WIDTH-1:1], 1'b1};
                    end else begin
                        acc_d = sh[2*WIDTH-1:0];
                    end
                end else begin
                    acc_d  = {mul_sum, 1'b0, acc_q[WIDTH-1:1]};
                    opnd_d = opnd_q << 1;
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIX: begin
                dz_d = 1'b0;
                if (op_q == MD_DIV) begin
                    if (bzero_q) begin
                        y_d  = '1;
                        dz_d = 1'b1;
                    end else begin
                        y_d = apply_sign(acc_q[WIDTH-1:0], sign_q);
                    end
                end else begin
                    y_d = acc_q[2*WIDTH-1:WIDTH];
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            dz_q    <= dz_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q    <= op_d;
        sign_q  <= sign_d;
        bzero_q <= bzero_d;
        opnd_q  <= opnd_d;
        acc_q   <= acc_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign div_zero  = dz_q;

endmodule
